// File: rtl/rct_pkg.sv
// rtl/rct_pkg.sv - shared types, constants and verdict function for the rct stimulus generator
package rct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] WORD0        = 32'h0000_0000;
    localparam logic [31:0] WORD1        = 32'h0000_0007;
    localparam logic [31:0] WORD2        = 32'h0000_0008;
    localparam logic [7:0]  VERDICT_MASK = 8'hF8;

    // Only a low byte in 1..7 is considered a failing word.
    function automatic logic exp_verdict(input logic [7:0] v);
        return (v == 8'h00) || ((v & VERDICT_MASK) != 8'h00);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/rct_lfsr.sv
// rtl/rct_lfsr.sv - 32-bit Galois right-shift LFSR with load and advance
module rct_lfsr
    import rct_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // A zero seed would lock the register up, so it is replaced by 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
        end else if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 32'd1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/rct_stim.sv
// rtl/rct_stim.sv - stimulus sequencer that drives words to a checker and scores its verdicts
module rct_stim
    import rct_pkg::*;
#(
    parameter int W  = 32,
    parameter int NW = 16,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  seed,
    input  logic [NW-1:0] count,
    output logic [W-1:0]  t,
    output logic          t_valid,
    input  logic          b,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [EW-1:0] err_cnt,
    output logic [W-1:0]  first_fail
);

    state_e        state_q, state_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  t_q, t_d;
    logic [EW-1:0] err_q, err_d;
    logic [W-1:0]  ff_q, ff_d;
    logic          pass_q, pass_d;

    logic          lfsr_load;
    logic          lfsr_en;
    logic [31:0]   lfsr_state;
    logic [NW-1:0] idx_inc;
    logic          mismatch;

    rct_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .seed_i  (32'(seed)),
        .en_i    (lfsr_en),
        .state_o (lfsr_state)
    );

    assign idx_inc = idx_q + NW'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        err_d     = err_q;
        ff_d      = ff_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        mismatch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = count;
                    idx_d     = '0;
                    err_d     = '0;
                    ff_d      = '0;
                    lfsr_load = 1'b1;
                    if (count == '0) begin
                        state_d = ST_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                        pass_d  = 1'b0;
                        t_d     = W'(WORD0);
                    end
                end
            end
            ST_DRIVE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                mismatch = (b != exp_verdict(t_q[7:0]));
                if (mismatch) begin
                    if (err_q != {EW{1'b1}}) begin
                        err_d = err_q + EW'(1);
                    end
                    // err_cnt never wraps, so zero means no earlier mismatch this run.
                    if (err_q == '0) begin
                        ff_d = t_q;
                    end
                end
                if (idx_inc < cnt_q) begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_inc;
                    case (idx_inc)
                        NW'(1):  t_d = W'(WORD1);
                        NW'(2):  t_d = W'(WORD2);
                        default: begin
                            t_d     = W'(lfsr_state);
                            lfsr_en = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign t          = t_q;
    assign t_valid    = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule
